tournament_select: RTL and testbench

Parametrised successor to the fixed four-lane PU/decoder selection datapath. It accepts a vector of N W-bit operands in one handshake and reduces it over log2(N) clocked pairwise-compare rounds to a single winner (maximum or minimum, selectable per job). It returns the winning value and its lane index. It sits between the operand memory and the result consumer, and has its own controller: no external en/sel sequencing.

---
 rtl/tournament_select_if.sv | 27 ++
 rtl/tournament_select.sv | 107 ++++++++++
 tb/tb_tournament_select.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/tournament_select_if.sv
// Handshake bundle for tournament_select: one operand vector in, one winner value/lane out.
interface tournament_select_if #(
    parameter int unsigned W = 32,
    parameter int unsigned N = 8
) ();
    localparam int unsigned IW = (N < 4) ? 1 : $clog2(N);

    logic          in_valid;
    logic          in_ready;
    logic [N*W-1:0] in_data;
    logic          mode;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [IW-1:0] out_idx;
    logic          busy;

    modport master (
        output in_valid, in_data, mode, out_ready,
        input  in_ready, out_valid, out_data, out_idx, busy
    );

    modport slave (
        input  in_valid, in_data, mode, out_ready,
        output in_ready, out_valid, out_data, out_idx, busy
    );
endinterface

// File: rtl/tournament_select.sv
// Tournament reduction of N W-bit lanes to one max/min winner plus its lane index,
// one pairwise-compare round per clock, log2(N) rounds per job.
module tournament_select #(
    parameter int unsigned W      = 32,
    parameter int unsigned N      = 8,
    parameter bit          SIGNED = 1'b0
) (
    input logic               clk,
    input logic               rst_n,
    tournament_select_if.slave bus
);
    localparam int unsigned L  = $clog2(N);
    localparam int unsigned IW = (N < 4) ? 1 : L;
    localparam int unsigned CW = $clog2(L + 1);
    localparam logic [CW-1:0] LastRound = CW'(L - 1);

    typedef enum logic [1:0] {StIdle, StReduce, StDone} state_e;

    state_e        state_q, state_d;
    logic [W-1:0]  val_q [N];
    logic [W-1:0]  val_d [N];
    logic [IW-1:0] tag_q [N];
    logic [IW-1:0] tag_d [N];
    logic [CW-1:0] round_q, round_d;
    logic          mode_q, mode_d;

    // Odd slot wins only when strictly better, so ties keep the lower tag.
    function automatic logic odd_wins(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic min_sel);
        logic [W-1:0] ak;
        logic [W-1:0] bk;
        ak = a;
        bk = b;
        if (SIGNED) begin
            ak[W-1] = ~ak[W-1];
            bk[W-1] = ~bk[W-1];
        end
        return min_sel ? (bk < ak) : (bk > ak);
    endfunction

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        mode_d  = mode_q;
        val_d   = val_q;
        tag_d   = tag_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < N; k++) begin
                        val_d[k] = bus.in_data[k*W +: W];
                        tag_d[k] = IW'(k);
                    end
                    mode_d  = bus.mode;
                    round_d = '0;
                    state_d = StReduce;
                end
            end
            StReduce: begin
                // Slots above the live range are rewritten with garbage; nothing live reads them.
                for (int k = 0; k < N / 2; k++) begin
                    if (odd_wins(val_q[2*k], val_q[2*k+1], mode_q)) begin
                        val_d[k] = val_q[2*k+1];
                        tag_d[k] = tag_q[2*k+1];
                    end else begin
                        val_d[k] = val_q[2*k];
                        tag_d[k] = tag_q[2*k];
                    end
                end
                round_d = round_q + CW'(1);
                if (round_q == LastRound) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            round_q <= '0;
            mode_q  <= 1'b0;
            for (int k = 0; k < N; k++) begin
                val_q[k] <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            val_q   <= val_d;
            tag_q   <= tag_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && rst_n;
    assign bus.out_valid = (state_q == StDone);
    assign bus.busy      = (state_q != StIdle);
    assign bus.out_data  = val_q[0];
    assign bus.out_idx   = tag_q[0];
endmodule

// File: tb/tb_tournament_select.sv
// Scoreboard bench: stimulus pushes expected {idx,data}; per-DUT monitors pop on each delivery.
module tb_tournament_select;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tournament_select_if #(.W(32), .N(8)) b8 ();
    tournament_select_if #(.W(8), .N(4)) b4s ();
    tournament_select_if #(.W(8), .N(4)) b4u ();

    tournament_select #(.W(32), .N(8), .SIGNED(1'b0)) dut8 (
        .clk(clk), .rst_n(rst_n), .bus(b8.slave)
    );
    tournament_select #(.W(8), .N(4), .SIGNED(1'b1)) dut4s (
        .clk(clk), .rst_n(rst_n), .bus(b4s.slave)
    );
    tournament_select #(.W(8), .N(4), .SIGNED(1'b0)) dut4u (
        .clk(clk), .rst_n(rst_n), .bus(b4u.slave)
    );

    logic [34:0] q8  [$];
    logic [9:0]  q4s [$];
    logic [9:0]  q4u [$];
    logic [34:0] e8;
    logic [9:0]  e4s;
    logic [9:0]  e4u;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (b8.out_valid && b8.out_ready) begin
            if (q8.size() == 0) chk("n8 unexpected out_valid", 1, 0);
            else begin
                e8 = q8.pop_front();
                chk("n8 out_data", b8.out_data, e8[31:0]);
                chk("n8 out_idx", b8.out_idx, e8[34:32]);
            end
        end
        if (b4s.out_valid && b4s.out_ready) begin
            if (q4s.size() == 0) chk("n4s unexpected out_valid", 1, 0);
            else begin
                e4s = q4s.pop_front();
                chk("n4s out_data", b4s.out_data, e4s[7:0]);
                chk("n4s out_idx", b4s.out_idx, e4s[9:8]);
            end
        end
        if (b4u.out_valid && b4u.out_ready) begin
            if (q4u.size() == 0) chk("n4u unexpected out_valid", 1, 0);
            else begin
                e4u = q4u.pop_front();
                chk("n4u out_data", b4u.out_data, e4u[7:0]);
                chk("n4u out_idx", b4u.out_idx, e4u[9:8]);
            end
        end
    end

    task automatic wait_ready8(input string name);
        int n = 0;
        while (!b8.in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk({name, " in_ready timeout"}, b8.in_ready, 1);
    endtask

    task automatic send8(input logic [255:0] d, input logic m, input logic [31:0] ed,
                         input logic [2:0] ei, input bit push);
        wait_ready8("send8");
        b8.in_valid = 1'b1;
        b8.in_data  = d;
        b8.mode     = m;
        if (push) q8.push_back({ei, ed});
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
    endtask

    task automatic send4(input logic [31:0] d, input logic m, input logic [7:0] sd,
                         input logic [1:0] si, input logic [7:0] ud, input logic [1:0] ui);
        int n = 0;
        while (!(b4s.in_ready && b4u.in_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 100) chk("send4 in_ready timeout", b4s.in_ready && b4u.in_ready, 1);
        b4s.in_valid = 1'b1;
        b4s.in_data  = d;
        b4s.mode     = m;
        b4u.in_valid = 1'b1;
        b4u.in_data  = d;
        b4u.mode     = m;
        q4s.push_back({si, sd});
        q4u.push_back({ui, ud});
        @(posedge clk);
        #1;
        b4s.in_valid = 1'b0;
        b4u.in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((q8.size() + q4s.size() + q4u.size()) != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, " drain pending"}, q8.size() + q4s.size() + q4u.size(), 0);
    endtask

    initial begin
        logic [255:0] va;
        logic [255:0] vf;
        logic [255:0] vr;
        logic [255:0] sv   [4];
        logic         sm   [4];
        logic [31:0]  sd   [4];
        logic [2:0]   si   [4];
        int           acc  [4];
        bit           seen;
        int           n;

        va = {32'd2, 32'd7, 32'd0, 32'd1, 32'd9, 32'd3, 32'd9, 32'd5};
        vf = {8{32'hFFFF_FFFF}};
        vr = {32'd80, 32'd70, 32'd60, 32'd50, 32'd40, 32'd30, 32'd20, 32'd10};

        b8.in_valid = 1'b1;  // held during reset: must not be captured
        b8.in_data = va;
        b8.mode = 1'b0;
        b8.out_ready = 1'b1;
        b4s.in_valid = 1'b0;
        b4s.in_data = '0;
        b4s.mode = 1'b0;
        b4s.out_ready = 1'b1;
        b4u.in_valid = 1'b0;
        b4u.in_data = '0;
        b4u.mode = 1'b0;
        b4u.out_ready = 1'b1;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", b8.in_ready, 0);
        chk("reset out_valid", b8.out_valid, 0);
        chk("reset out_data", b8.out_data, 0);
        chk("reset out_idx", b8.out_idx, 0);
        chk("reset busy", b8.busy, 0);
        b8.in_valid = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("post-reset in_ready", b8.in_ready, 1);
        chk("post-reset n4 in_ready", b4s.in_ready, 1);

        // Latency: out_valid first visible after the third round edge.
        send8(va, 1'b0, 32'd9, 3'd1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency out_valid after E%0d", c), b8.out_valid, (c == 3));
        end
        drain("max");

        send8(va, 1'b1, 32'd0, 3'd5, 1'b1);
        send8(vf, 1'b0, 32'hFFFF_FFFF, 3'd0, 1'b1);
        send8(vf, 1'b1, 32'hFFFF_FFFF, 3'd0, 1'b1);
        drain("n8 set");

        send4({8'h01, 8'hFF, 8'h7F, 8'h80}, 1'b0, 8'h7F, 2'd1, 8'hFF, 2'd2);
        send4({8'h01, 8'hFF, 8'h7F, 8'h80}, 1'b1, 8'h80, 2'd0, 8'h01, 2'd3);
        send4({8'h80, 8'h80, 8'h80, 8'h80}, 1'b0, 8'h80, 2'd0, 8'h80, 2'd0);
        send4({8'h05, 8'h00, 8'h00, 8'h00}, 1'b0, 8'h05, 2'd3, 8'h05, 2'd3);
        drain("n4 set");

        // Backpressure while a new vector is offered.
        b8.out_ready = 1'b0;
        send8(va, 1'b0, 32'd9, 3'd1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        b8.in_valid = 1'b1;
        b8.in_data  = vf;
        b8.mode     = 1'b1;
        q8.push_back({3'd0, 32'hFFFF_FFFF});
        for (int i = 0; i < 5; i++) begin
            chk("bp out_valid", b8.out_valid, 1);
            chk("bp out_data", b8.out_data, 32'd9);
            chk("bp out_idx", b8.out_idx, 1);
            chk("bp in_ready", b8.in_ready, 0);
            @(posedge clk);
            #1;
        end
        b8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp released in_ready", b8.in_ready, 1);
        chk("bp released out_valid", b8.out_valid, 0);
        @(posedge clk);
        #1;
        b8.in_valid = 1'b0;
        chk("bp new job busy", b8.busy, 1);
        drain("backpressure");

        // Reset one cycle after accept aborts the job.
        send8(va, 1'b0, 32'd9, 3'd1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort out_valid", b8.out_valid, 0);
        chk("abort out_data", b8.out_data, 0);
        chk("abort busy", b8.busy, 0);
        chk("abort in_ready low", b8.in_ready, 0);
        rst_n = 1'b1;
        #1;
        chk("abort in_ready", b8.in_ready, 1);
        seen = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            seen |= b8.out_valid;
        end
        chk("abort no out_valid", seen, 0);

        // Streaming: in_valid and out_ready held high, mode toggles per job.
        sv[0] = va; sm[0] = 1'b0; sd[0] = 32'd9;  si[0] = 3'd1;
        sv[1] = va; sm[1] = 1'b1; sd[1] = 32'd0;  si[1] = 3'd5;
        sv[2] = vr; sm[2] = 1'b0; sd[2] = 32'd80; si[2] = 3'd7;
        sv[3] = vr; sm[3] = 1'b1; sd[3] = 32'd10; si[3] = 3'd0;
        b8.in_valid = 1'b1;
        for (int j = 0; j < 4; j++) begin
            n = 0;
            while (!b8.in_ready && n < 50) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (n >= 50) chk("stream in_ready timeout", b8.in_ready, 1);
            b8.in_data = sv[j];
            b8.mode    = sm[j];
            q8.push_back({si[j], sd[j]});
            @(posedge clk);
            #1;
            acc[j] = cyc;
            if (j > 0) chk("stream period", acc[j] - acc[j-1], 5);
        end
        b8.in_valid = 1'b0;
        drain("stream");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
